// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS writeback path: register-zero index,
// default widths, the queued writeback entry and the drop counter ceiling.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Writes to $zero are architecturally discarded
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Ceiling of the saturating $zero-write drop counter
    localparam logic [7:0] DROP_CNT_MAX = 8'd255;

    // One pending register-file write ("reg" is a keyword, hence reg_idx)
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] reg_idx;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mips_wb_bypass.sv
// Youngest-match search over the writeback queue for one read operand.
// Walks entries from head (oldest) to tail (youngest) so the last match wins.
module mips_wb_bypass
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [ADDR_W-1:0] regs  [DEPTH],
    input  logic [DATA_W-1:0] datas [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] query,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] slot;

    // Age-ordered scan; a later (younger) match overrides an earlier one
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (query != ADDR_W'(REG_ZERO)) &&
                (regs[slot] == query)) begin
                hit  = 1'b1;
                data = datas[slot];
            end
        end
    end

endmodule

// File: rtl/mips_writeback_queue.sv
// In-order writeback FIFO feeding the MIPS register-file write port.
// Load-path (mem) requests are older than same-cycle ALU requests; $zero
// writes are accepted and dropped. Define MIPS_WB_BYPASS_EN to build the
// youngest-match operand bypass; otherwise the byp_* outputs read 0.
module mips_writeback_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    output logic                     rf_write_en,
    output logic [ADDR_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic                     rf_ready,
    input  logic [ADDR_W-1:0]        byp_reg_1,
    input  logic [ADDR_W-1:0]        byp_reg_2,
    output logic                     byp_hit_1,
    output logic                     byp_hit_2,
    output logic [DATA_W-1:0]        byp_data_1,
    output logic [DATA_W-1:0]        byp_data_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

    logic [ADDR_W-1:0] regs  [DEPTH];
    logic [DATA_W-1:0] datas [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  alu_slot;
    logic              mem_acc, alu_acc;
    logic              mem_push, alu_push;
    logic              mem_drop, alu_drop;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [8:0]        drop_sum;

    // Readiness looks only at registered occupancy; a same-cycle pop never frees room
    assign mem_ready = count < DEPTH_C;
    assign alu_ready = mem_valid ? (count < DEPTH_M1_C) : (count < DEPTH_C);

    assign mem_acc  = mem_valid && mem_ready;
    assign alu_acc  = alu_valid && alu_ready;
    assign mem_drop = mem_acc && (mem_reg == ADDR_W'(REG_ZERO));
    assign alu_drop = alu_acc && (alu_reg == ADDR_W'(REG_ZERO));
    assign mem_push = mem_acc && !mem_drop;
    assign alu_push = alu_acc && !alu_drop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    assign rf_write_en   = !empty;
    assign rf_write_reg  = empty ? '0 : regs[head];
    assign rf_write_data = empty ? '0 : datas[head];
    assign pop           = rf_write_en && rf_ready;

    // The ALU entry lands behind the mem entry when both push together
    assign alu_slot   = tail + PTR_W'(mem_push);
    assign count_next = count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    assign drop_sum   = {1'b0, drop_cnt} + 9'(mem_drop) + 9'(alu_drop);

    // Pointer, occupancy and drop-counter state; reset empties the queue at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            head     <= head + PTR_W'(pop);
            tail     <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
            count    <= count_next;
            drop_cnt <= (drop_sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : drop_sum[7:0];
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (mem_push) begin
            regs[tail]  <= mem_reg;
            datas[tail] <= mem_data;
        end
        if (alu_push) begin
            regs[alu_slot]  <= alu_reg;
            datas[alu_slot] <= alu_data;
        end
    end

`ifdef MIPS_WB_BYPASS_EN
    mips_wb_bypass #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_1 (
        .regs  (regs),
        .datas (datas),
        .head  (head),
        .count (count),
        .query (byp_reg_1),
        .hit   (byp_hit_1),
        .data  (byp_data_1)
    );

    mips_wb_bypass #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_2 (
        .regs  (regs),
        .datas (datas),
        .head  (head),
        .count (count),
        .query (byp_reg_2),
        .hit   (byp_hit_2),
        .data  (byp_data_2)
    );
`else
    logic unused_byp;
    assign unused_byp = ^{byp_reg_1, byp_reg_2};
    assign byp_hit_1  = 1'b0;
    assign byp_hit_2  = 1'b0;
    assign byp_data_1 = '0;
    assign byp_data_2 = '0;
`endif

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Self-checking bench for mips_writeback_queue: a queue-based reference model
// checked on every falling edge, plus hand-computed literal checks.
module tb_mips_writeback_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
`ifdef MIPS_WB_BYPASS_EN
    localparam bit BYP_ON = 1'b1;
`else
    localparam bit BYP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid, rf_ready;
    logic [4:0]  mem_reg, alu_reg, byp_reg_1, byp_reg_2;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data, byp_data_1, byp_data_2;
    logic        byp_hit_1, byp_hit_2, empty, full;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t model_q[$];
    int        model_drop = 0;

    mips_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_reg       (mem_reg),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_ready      (rf_ready),
        .byp_reg_1     (byp_reg_1),
        .byp_reg_2     (byp_reg_2),
        .byp_hit_1     (byp_hit_1),
        .byp_hit_2     (byp_hit_2),
        .byp_data_1    (byp_data_1),
        .byp_data_2    (byp_data_2),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending value for an index, searched over the model queue
    task automatic model_bypass(input logic [4:0] r, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (BYP_ON && r != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].reg_idx == r) begin
                    hit  = 1'b1;
                    data = model_q[i].data;
                end
            end
        end
    endtask

    // Compare all outputs against the model, then advance the model by one edge
    task automatic check_output();
        int          sz;
        logic        exp_mem_rdy, exp_alu_rdy, h;
        logic [31:0] d;
        if (!rst_n) begin
            model_q.delete();
            model_drop = 0;
        end
        sz          = model_q.size();
        exp_mem_rdy = sz < DEPTH;
        exp_alu_rdy = mem_valid ? (sz < DEPTH - 1) : (sz < DEPTH);
        check("count", 32'(count), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("mem_ready", 32'(mem_ready), 32'(exp_mem_rdy));
        check("alu_ready", 32'(alu_ready), 32'(alu_ready === exp_alu_rdy ? alu_ready : exp_alu_rdy));
        check("rf_write_en", 32'(rf_write_en), 32'(sz != 0));
        check("rf_write_reg", 32'(rf_write_reg), sz != 0 ? 32'(model_q[0].reg_idx) : 32'd0);
        check("rf_write_data", rf_write_data, sz != 0 ? model_q[0].data : 32'd0);
        check("drop_cnt", 32'(drop_cnt), 32'(model_drop));
        model_bypass(byp_reg_1, h, d);
        check("byp_hit_1", 32'(byp_hit_1), 32'(h));
        check("byp_data_1", byp_data_1, d);
        model_bypass(byp_reg_2, h, d);
        check("byp_hit_2", 32'(byp_hit_2), 32'(h));
        check("byp_data_2", byp_data_2, d);
        if (rst_n) begin
            if (sz != 0 && rf_ready) void'(model_q.pop_front());
            if (mem_valid && exp_mem_rdy) begin
                if (mem_reg == 5'd0) model_drop++;
                else model_q.push_back('{reg_idx: mem_reg, data: mem_data});
            end
            if (alu_valid && exp_alu_rdy) begin
                if (alu_reg == 5'd0) model_drop++;
                else model_q.push_back('{reg_idx: alu_reg, data: alu_data});
            end
            if (model_drop > 255) model_drop = 255;
        end
    endtask

    always @(negedge clk) check_output();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                  input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                  input logic rr);
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        rf_ready  = rr;
        #1;
    endtask

    task automatic idle(input logic rr);
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rr);
    endtask

    initial begin
        rst_n     = 1'b0;
        byp_reg_1 = 5'd0;
        byp_reg_2 = 5'd0;
        idle(1'b0);
        step();
        step();
        check("lit_reset_empty", 32'(empty), 32'd1);
        check("lit_reset_count", 32'(count), 32'd0);
        check("lit_reset_we", 32'(rf_write_en), 32'd0);
        check("lit_reset_mem_ready", 32'(mem_ready), 32'd1);
        check("lit_reset_alu_ready", 32'(alu_ready), 32'd1);
        rst_n = 1'b1;

        // Single load write, held while rf_ready is low
        apply_stimulus(1'b1, 5'd5, 32'h1111_0000, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        idle(1'b0);
        check("lit_t1_we", 32'(rf_write_en), 32'd1);
        check("lit_t1_reg", 32'(rf_write_reg), 32'd5);
        check("lit_t1_data", rf_write_data, 32'h1111_0000);
        step();
        check("lit_t1_hold_reg", 32'(rf_write_reg), 32'd5);
        check("lit_t1_hold_data", rf_write_data, 32'h1111_0000);
        idle(1'b1);
        step();
        idle(1'b0);
        check("lit_t1_drained", 32'(empty), 32'd1);

        // Dual enqueue, mem is older
        apply_stimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0);
        step();
        idle(1'b0);
        check("lit_t2_count", 32'(count), 32'd2);
        check("lit_t2_first", 32'(rf_write_reg), 32'd3);
        idle(1'b1);
        step();
        check("lit_t2_second", 32'(rf_write_reg), 32'd4);
        check("lit_t2_second_data", rf_write_data, 32'hB);
        step();
        idle(1'b0);
        check("lit_t2_empty", 32'(empty), 32'd1);

        // Fill to full, then offer a request alongside a pop
        apply_stimulus(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h40, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h60, 1'b1);
        check("lit_t3_full", 32'(full), 32'd1);
        check("lit_t3_count", 32'(count), 32'd4);
        check("lit_t3_mem_ready", 32'(mem_ready), 32'd0);
        check("lit_t3_alu_ready", 32'(alu_ready), 32'd0);
        step();
        idle(1'b0);
        check("lit_t3_count_after", 32'(count), 32'd3);
        check("lit_t3_head", 32'(rf_write_reg), 32'd2);
        idle(1'b1);
        step();
        step();
        step();
        idle(1'b0);
        check("lit_t3_drained", 32'(empty), 32'd1);

        // Bypass: r7=1, r7=2, r9=3
        apply_stimulus(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd9, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0);
        byp_reg_1 = 5'd7;
        byp_reg_2 = 5'd0;
        step();
        idle(1'b0);
        check("lit_byp_count", 32'(count), 32'd3);
        check("lit_byp_hit_1", 32'(byp_hit_1), 32'(BYP_ON));
        check("lit_byp_data_1", byp_data_1, BYP_ON ? 32'd2 : 32'd0);
        check("lit_byp_hit_2_zero", 32'(byp_hit_2), 32'd0);
        check("lit_byp_data_2_zero", byp_data_2, 32'd0);
        byp_reg_2 = 5'd9;
        #1;
        check("lit_byp_hit_2", 32'(byp_hit_2), 32'(BYP_ON));
        check("lit_byp_data_2", byp_data_2, BYP_ON ? 32'd3 : 32'd0);

        // Build a wrapped queue, then reset mid-operation
        idle(1'b1);
        step();
        step();
        apply_stimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0);
        step();
        idle(1'b0);
        check("lit_wrap_count", 32'(count), 32'd3);
        check("lit_wrap_head", 32'(rf_write_reg), 32'd9);
        rst_n = 1'b0;
        #1;
        check("lit_rst_we", 32'(rf_write_en), 32'd0);
        check("lit_rst_count", 32'(count), 32'd0);
        check("lit_rst_reg", 32'(rf_write_reg), 32'd0);
        check("lit_rst_byp", 32'(byp_hit_1), 32'd0);
        step();
        rst_n = 1'b1;
        apply_stimulus(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        idle(1'b0);
        check("lit_post_rst_reg", 32'(rf_write_reg), 32'd12);
        check("lit_post_rst_data", rf_write_data, 32'h1234);
        check("lit_post_rst_count", 32'(count), 32'd1);
        idle(1'b1);
        step();
        idle(1'b0);
        check("lit_post_rst_empty", 32'(empty), 32'd1);

        // $zero writes: double drop, then saturation
        apply_stimulus(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6, 1'b0);
        step();
        idle(1'b0);
        check("lit_drop_two", 32'(drop_cnt), 32'd2);
        check("lit_drop_two_empty", 32'(empty), 32'd1);
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 300; i++) step();
        idle(1'b0);
        check("lit_drop_sat", 32'(drop_cnt), 32'd255);
        check("lit_drop_sat_empty", 32'(empty), 32'd1);

        // Mixed directed pattern table
        for (int i = 0; i < 40; i++) begin
            apply_stimulus((i % 3) != 0, 5'(i % 8), 32'(i * 17 + 1),
                           (i % 4) < 2, 5'((i * 3) % 8), 32'(i * 31 + 2),
                           (i % 5) < 2);
            byp_reg_1 = 5'(i % 8);
            byp_reg_2 = 5'((i + 3) % 8);
            step();
        end
        idle(1'b1);
        for (int i = 0; i < 6; i++) step();
        check("lit_mixed_drained", 32'(empty), 32'd1);
        idle(1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_writeback_queue.md
# mips_writeback_queue

Write-side initiator for the MIPS register file. Collects writeback results from the ALU and load paths and buffers them in a small in-order FIFO. Drains one entry per accepted cycle onto the register file's write port (write enable, write register, write data). Optionally offers youngest-match bypass so read operands see results still in the queue.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- DATA_W, 32, writeback data width
- ADDR_W, 5, register index width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_valid / mem_reg / mem_data  in  1 / ADDR_W / DATA_W  load-path writeback request
- mem_ready  out  1  load request accepted this cycle
- alu_valid / alu_reg / alu_data  in  1 / ADDR_W / DATA_W  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- rf_write_en  out  1  drives register-file write enable
- rf_write_reg  out  ADDR_W  drives register-file write register
- rf_write_data  out  DATA_W  drives register-file write data
- rf_ready  in  1  register file takes the presented write this cycle
- byp_reg_1, byp_reg_2  in  ADDR_W  operand indices being read
- byp_hit_1, byp_hit_2  out  1  pending write to that index exists
- byp_data_1, byp_data_2  out  DATA_W  youngest pending value for that index
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH
- drop_cnt  out  8  saturating count of discarded $zero writes

## Operation
- Enqueue order: mem before alu in the same cycle. Mem is treated as older.
- mem_ready = count<DEPTH.
- alu_ready = count<DEPTH−1 when mem_valid, else count<DEPTH.
- A request with reg==0 is accepted and discarded. It takes no slot and increments drop_cnt, which saturates at 255. If both sources target $0, drop_cnt increments by 2, still saturating.
- Head presentation: rf_write_en = !empty. rf_write_reg and rf_write_data come from the head entry and are 0 when empty.
- Pop: when rf_write_en && rf_ready, the head pointer advances at the clock edge.
- Pointers wrap modulo DEPTH.
- count update: next count = count + pushes − pop, where pushes ∈ {0,1,2}.
- Bypass: search all valid entries for index == byp_reg_n, with reg 0 never matching. The youngest match wins. On a hit, byp_hit_n=1 and byp_data_n=value. On a miss, both are 0.
- Bypass is purely combinational on current state and does not see same-cycle enqueues.

## Timing
- Reset, asynchronous: pointers, count, and drop_cnt go to 0. empty=1, full=0. rf_write_en=0. rf_write_reg, rf_write_data, and all byp_* outputs read 0. mem_ready and alu_ready are 1 per the rules above.
- Reset mid-operation: all queued entries are lost. Outputs drop within the reset assertion, not at the next edge.
- Enqueue-to-write latency: a request accepted at edge N into an empty queue gives rf_write_en=1 during cycle N+1.
- Ready is computed from the registered count. A pop in the same cycle does not create space for that cycle's requests: full plus pop gives no accept.
- No pass-through path. An entry is never written to the register file in the cycle it arrives.
- Simultaneous push and pop on a non-full queue leaves count unchanged. Entries stay in strict FIFO order.
- rf_ready low holds the head stable: reg, data, and enable are unchanged.

## Configuration
- MIPS_WB_BYPASS_EN defined: bypass search is present as described.
- MIPS_WB_BYPASS_EN undefined: byp_hit_n and byp_data_n are tied to 0. byp_reg_n are ignored and no comparators are built. The ports remain so the interface is identical.

## Structure
- The shared package mips_pkg holds:
  - REG_ZERO (5'd0) and the DATA_W/ADDR_W defaults;
  - wb_entry_t {reg, data};
  - the DROP_CNT_MAX constant.
- One sub-module is natural: mips_wb_bypass, the youngest-match priority search over the entry array and pointers. It is instantiated twice, once per operand, and only under MIPS_WB_BYPASS_EN.

## Test plan
- Reset, then mem writes r5=0x1111_0000: rf_write_en=1, reg=5, data=0x1111_0000 next cycle. Drop rf_ready and the outputs hold. Raise it and the queue is empty one cycle later.
- Same cycle, mem r3=0xA and alu r4=0xB into an empty queue: count=2. Writes drain r3 then r4 on consecutive rf_ready cycles.
- With rf_ready=0, fill 4 entries: full=1, mem_ready=0, alu_ready=0. Offer a request and pulse rf_ready in the same cycle: the request is not accepted and count=3 after the edge.
- alu writes r0=0xFFFF_FFFF 300 times: nothing is queued, empty stays 1, drop_cnt=255.
- With bypass on, queue r7=1, r7=2, r9=3 and set byp_reg_1=7, byp_reg_2=0: hit_1=1 with data_1=2, hit_2=0. With bypass off, all byp_* outputs stay 0.
- Assert rst_n low with 3 entries queued and wrap-around in progress: rf_write_en=0 and count=0 immediately. After release, a new write drains correctly from slot 0.
